// File: rtl/cpu_mem_stage.sv
// MEM stage of the pipelined MIPS core: sized loads/stores over four byte-lane banks,
// alignment-fault detection, a configurable load latency that stalls upstream, and the MEM/WB register.

module cpu_mem_lane #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);
  logic [7:0] bank [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) bank[idx] <= wdata;
  end

  assign rdata = bank[idx];
endmodule

module cpu_mem_stage #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [31:0] current_pc,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic        reg_write_en_in,
  input  logic [4:0]  reg_write_num_in,
  input  logic [1:0]  wb_sel,
  input  logic [31:0] reg_read2_data,
  input  logic [31:0] alu_result,
  output logic        stall,
  output logic [31:0] dm_read_data,
  output logic        reg_write_en,
  output logic [4:0]  reg_write_num,
  output logic [31:0] reg_write_data,
  output logic        mem_fault,
  output logic [31:0] fault_addr
);
  localparam int NUM_LANES = 4;
  localparam bit HAS_WAIT = (LATENCY > 0);
  localparam logic [2:0] CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic        en;
    logic [4:0]  num;
    logic [31:0] data;
    logic [31:0] dm;
    logic        fault;
  } wb_t;

  state_t state_q;
  logic [2:0] cnt_q;
  wb_t wb_q, wb_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic [ADDR_W-1:0] widx;
  logic [1:0] lane;
  logic is_byte, is_half, is_word;
  logic misaligned, fault, ld_req, st_go, take;
  logic [NUM_LANES-1:0] be;
  logic [NUM_LANES-1:0][7:0] wr_lanes, rd_lanes;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;

  assign widx    = alu_result[ADDR_W+1:2];
  assign lane    = alu_result[1:0];
  assign is_byte = (mem_size == 2'd0);
  assign is_half = (mem_size == 2'd1);
  assign is_word = mem_size[1];

  assign misaligned = (is_half & lane[0]) | (is_word & (|lane));
  assign fault      = in_valid & (mem_rd | mem_wr) & misaligned;
  // a store wins over a simultaneous read, so only a pure read is a load
  assign ld_req     = in_valid & mem_rd & ~mem_wr & ~misaligned;
  assign st_go      = in_valid & mem_wr & ~misaligned & ~stall;

  // Mealy while idle, Moore while waiting; reset forces it low immediately
  assign stall = ~clr & ((state_q == WAIT) ? (cnt_q != 3'd0) : (ld_req & HAS_WAIT));
  assign take  = in_valid & ~stall;

  always_comb begin
    be = 4'b0000;
    if (is_byte)      be = 4'b0001 << lane;
    else if (is_half) be = lane[1] ? 4'b1100 : 4'b0011;
    else              be = 4'b1111;
  end

  always_comb begin
    wr_lanes = reg_read2_data;
    if (is_byte)      wr_lanes = {4{reg_read2_data[7:0]}};
    else if (is_half) wr_lanes = {2{reg_read2_data[15:0]}};
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    cpu_mem_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk   (clk),
      .we    (st_go & be[g]),
      .idx   (widx),
      .wdata (wr_lanes[g]),
      .rdata (rd_lanes[g])
    );
  end

  assign byte_sel = rd_lanes[lane];
  assign half_sel = lane[1] ? rd_lanes[3:2] : rd_lanes[1:0];

  always_comb begin
    ld_ext = rd_lanes;
    if (is_byte)      ld_ext = mem_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    else if (is_half) ld_ext = mem_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
  end

  always_comb begin
    wb_d = '0;
    fault_addr_d = fault_addr_q;
    if (take) begin
      wb_d.en    = reg_write_en_in & ~fault & (reg_write_num_in != 5'd0);
      wb_d.num   = reg_write_num_in;
      wb_d.dm    = ld_req ? ld_ext : 32'd0;
      wb_d.fault = fault;
      case (wb_sel)
        2'd0:    wb_d.data = alu_result;
        2'd1:    wb_d.data = wb_d.dm;
        2'd2:    wb_d.data = current_pc + 32'd1;
        default: wb_d.data = 32'd0;
      endcase
      if (fault) fault_addr_d = alu_result;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        IDLE: if (ld_req && HAS_WAIT) begin
          state_q <= WAIT;
          cnt_q   <= CNT_INIT;
        end
        WAIT: if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
              else               state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wb_q         <= '0;
      fault_addr_q <= 32'd0;
    end else begin
      wb_q         <= wb_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign dm_read_data   = wb_q.dm;
  assign reg_write_en   = wb_q.en;
  assign reg_write_num  = wb_q.num;
  assign reg_write_data = wb_q.data;
  assign mem_fault      = wb_q.fault;
  assign fault_addr     = fault_addr_q;
endmodule

// File: tb/tb_cpu_mem_stage.sv
// Bench for cpu_mem_stage: three instances (LATENCY 0, 2, 3) checked against a byte-array
// memory model with directed steps followed by random instruction streams.

module tb_cpu_mem_stage;
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic        in_valid [3], mem_rd [3], mem_wr [3], mem_uns [3], rwe_in [3];
  logic [1:0]  sz [3], wbs [3];
  logic [4:0]  num_in [3];
  logic [31:0] pc [3], rt [3], alu [3];
  logic        stall_o [3], rwe_o [3], mf_o [3];
  logic [4:0]  rwn_o [3];
  logic [31:0] dm_o [3], rwd_o [3], fa_o [3];

  int nvec = 0, nerr = 0;
  logic [7:0]  mdl  [3][1024];
  logic [31:0] fa_m [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cpu_mem_stage #(.ADDR_W(8), .LATENCY(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
      .clk(clk), .clr(clr), .in_valid(in_valid[g]), .current_pc(pc[g]),
      .mem_rd(mem_rd[g]), .mem_wr(mem_wr[g]), .mem_size(sz[g]), .mem_unsigned(mem_uns[g]),
      .reg_write_en_in(rwe_in[g]), .reg_write_num_in(num_in[g]), .wb_sel(wbs[g]),
      .reg_read2_data(rt[g]), .alu_result(alu[g]), .stall(stall_o[g]),
      .dm_read_data(dm_o[g]), .reg_write_en(rwe_o[g]), .reg_write_num(rwn_o[g]),
      .reg_write_data(rwd_o[g]), .mem_fault(mf_o[g]), .fault_addr(fa_o[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic bit misal(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd1 && a[0]) || (s[1] && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] mdl_load(input int d, input logic [31:0] a,
                                           input logic [1:0] s, input logic u);
    int b = int'(a[9:0]);
    int h = b & ~1;
    int w = b & ~3;
    logic [7:0]  by;
    logic [15:0] hw;
    case (s)
      2'd0: begin
        by = mdl[d][b];
        return u ? {24'b0, by} : {{24{by[7]}}, by};
      end
      2'd1: begin
        hw = {mdl[d][h+1], mdl[d][h]};
        return u ? {16'b0, hw} : {{16{hw[15]}}, hw};
      end
      default: return {mdl[d][w+3], mdl[d][w+2], mdl[d][w+1], mdl[d][w]};
    endcase
  endfunction

  task automatic mdl_store(input int d, input logic [31:0] a, input logic [1:0] s, input logic [31:0] r);
    int b = int'(a[9:0]);
    case (s)
      2'd0: mdl[d][b] = r[7:0];
      2'd1: begin mdl[d][b] = r[7:0]; mdl[d][b+1] = r[15:8]; end
      default: for (int i = 0; i < 4; i++) mdl[d][b+i] = r[8*i +: 8];
    endcase
  endtask

  task automatic drive(input int d, input logic v, rd, wr, input logic [1:0] s, input logic u, we,
                       input logic [4:0] n, input logic [1:0] ws, input logic [31:0] p, r, a);
    in_valid[d] = v; mem_rd[d] = rd; mem_wr[d] = wr; sz[d] = s; mem_uns[d] = u;
    rwe_in[d] = we; num_in[d] = n; wbs[d] = ws; pc[d] = p; rt[d] = r; alu[d] = a;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) drive(d, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Issue one instruction, hold it while stalled, then check the MEM/WB result.
  task automatic do_op(input int d, input logic v, rd, wr, input logic [1:0] s, input logic u, we,
                       input logic [4:0] n, input logic [1:0] ws, input logic [31:0] p, r, a,
                       input string tag);
    bit mis, isld, isst;
    logic [31:0] edm, erwd;
    int ns = 0;
    drive(d, v, rd, wr, s, u, we, n, ws, p, r, a);
    mis  = v && (rd || wr) && misal(s, a);
    isld = v && rd && !wr && !mis;
    isst = v && wr && !mis;
    edm  = isld ? mdl_load(d, a, s, u) : 32'd0;
    case (ws)
      2'd0:    erwd = a;
      2'd1:    erwd = edm;
      2'd2:    erwd = p + 32'd1;
      default: erwd = 32'd0;
    endcase
    #1;
    while (stall_o[d] === 1'b1 && ns < 12) begin
      @(posedge clk); #1;
      ns++;
      chk({tag, ":bubble"}, {30'b0, rwe_o[d], mf_o[d]}, 32'd0);
    end
    chk({tag, ":stall_cycles"}, 32'(ns), isld ? 32'(lat_of(d)) : 32'd0);
    @(posedge clk); #1;
    if (isst) mdl_store(d, a, s, r);
    if (mis) fa_m[d] = a;
    chk({tag, ":dm"},   dm_o[d], edm);
    chk({tag, ":rwe"},  32'(rwe_o[d]), 32'(v && we && !mis && n != 5'd0));
    chk({tag, ":rwn"},  32'(rwn_o[d]), v ? 32'(n) : 32'd0);
    chk({tag, ":rwd"},  rwd_o[d], v ? erwd : 32'd0);
    chk({tag, ":fault"}, 32'(mf_o[d]), 32'(mis));
    chk({tag, ":faddr"}, fa_o[d], fa_m[d]);
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, ":stall"}, 32'(stall_o[d]), 32'd0);
    chk({tag, ":dm"},    dm_o[d], 32'd0);
    chk({tag, ":rwe"},   32'(rwe_o[d]), 32'd0);
    chk({tag, ":rwn"},   32'(rwn_o[d]), 32'd0);
    chk({tag, ":rwd"},   rwd_o[d], 32'd0);
    chk({tag, ":fault"}, 32'(mf_o[d]), 32'd0);
    chk({tag, ":faddr"}, fa_o[d], 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic v, rd, wr, u, we;
    logic [1:0] s, ws, k;
    logic [31:0] a;
    for (int d = 0; d < 3; d++) fa_m[d] = 32'd0;
    idle_all();
    clr = 1'b1;
    #3;
    for (int d = 0; d < 3; d++) chk_zero(d, "reset");
    @(negedge clk) clr = 1'b0;

    // sized accesses, LATENCY=2
    do_op(1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h10, "sw10");
    do_op(1, 1, 1, 0, 0, 0, 1, 5, 1, 0, 0, 32'h13, "lb13");
    chk("lb13_lit", dm_o[1], 32'hFFFFFFDE);
    do_op(1, 1, 1, 0, 0, 1, 1, 5, 1, 0, 0, 32'h13, "lbu13");
    chk("lbu13_lit", dm_o[1], 32'h000000DE);
    do_op(1, 1, 1, 0, 1, 0, 1, 6, 1, 0, 0, 32'h12, "lh12");
    chk("lh12_lit", dm_o[1], 32'hFFFFDEAD);
    do_op(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h55, 32'h11, "sb11");
    do_op(1, 1, 1, 0, 2, 0, 1, 7, 1, 0, 0, 32'h10, "lw10a");
    chk("lw10a_lit", dm_o[1], 32'hDEAD55EF);
    do_op(1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 32'h1234, 32'h10, "sh10");
    do_op(1, 1, 1, 0, 2, 0, 1, 7, 1, 0, 0, 32'h10, "lw10b");
    chk("lw10b_lit", dm_o[1], 32'hDEAD1234);
    do_op(1, 1, 1, 0, 2, 0, 1, 7, 1, 0, 0, 32'h06, "lw06");
    chk("lw06_fault_lit", 32'(mf_o[1]), 32'd1);
    chk("lw06_faddr_lit", fa_o[1], 32'h6);
    do_op(1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 32'h0BADF00D, 32'h12, "sw12mis");
    do_op(1, 1, 1, 0, 2, 0, 1, 8, 1, 0, 0, 32'h10, "lw10c");
    chk("lw10c_lit", dm_o[1], 32'hDEAD1234);
    do_op(1, 1, 0, 0, 2, 0, 1, 31, 2, 32'h40, 0, 32'h123, "pc_r31");
    chk("pc_r31_lit", rwd_o[1], 32'h41);
    do_op(1, 1, 0, 0, 2, 0, 1, 0, 2, 32'h40, 0, 32'h123, "pc_r0");
    chk("pc_r0_lit", 32'(rwe_o[1]), 32'd0);
    do_op(1, 0, 1, 0, 2, 0, 1, 3, 0, 0, 0, 32'h10, "bubble");
    do_op(1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 32'hCAFEF00D, 32'h400, "sw400_l2");
    do_op(1, 1, 1, 0, 2, 0, 1, 9, 1, 0, 0, 32'h000, "lw000_l2");
    chk("wrap_l2_lit", dm_o[1], 32'hCAFEF00D);
    idle_all();

    // wrap with single-cycle read
    do_op(0, 1, 0, 1, 2, 0, 0, 0, 0, 0, 32'hCAFEF00D, 32'h400, "sw400_l0");
    do_op(0, 1, 1, 0, 2, 0, 1, 9, 1, 0, 0, 32'h000, "lw000_l0");
    chk("wrap_l0_lit", dm_o[0], 32'hCAFEF00D);
    idle_all();

    // asynchronous reset in the middle of a LATENCY=3 load
    do_op(2, 1, 0, 1, 2, 0, 0, 0, 0, 0, 32'h11223344, 32'h10, "rst_sw");
    do_op(2, 1, 1, 0, 2, 0, 1, 4, 1, 0, 0, 32'h06, "rst_fault");
    drive(2, 1, 1, 0, 2, 0, 1, 4, 1, 0, 0, 32'h10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_midwait_stall", 32'(stall_o[2]), 32'd1);
    #1 clr = 1'b1;
    #1;
    chk_zero(2, "rst_async");
    for (int d = 0; d < 3; d++) fa_m[d] = 32'd0;
    @(negedge clk) clr = 1'b0;
    do_op(2, 1, 1, 0, 2, 0, 1, 4, 1, 0, 0, 32'h10, "rst_reload");
    idle_all();

    // random streams over a pre-initialised 16-word window
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 16; w++)
        do_op(d, 1, 0, 1, 2, 0, 0, 0, 0, 0, $urandom, 32'(w * 4), "init");
      for (int i = 0; i < 60; i++) begin
        v  = ($urandom_range(0, 9) != 0);
        k  = 2'($urandom_range(0, 3));
        rd = (k == 2'd1 || k == 2'd3);
        wr = (k == 2'd2 || k == 2'd3);
        s  = 2'($urandom_range(0, 3));
        u  = 1'($urandom_range(0, 1));
        we = 1'($urandom_range(0, 1));
        ws = 2'($urandom_range(0, 3));
        if (k == 2'd0) a = $urandom;
        else a = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63));
        do_op(d, v, rd, wr, s, u, we, 5'($urandom), ws, $urandom, $urandom, a, "rand");
      end
      idle_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
